// File: rtl/axi_lite_slave_regs.sv
// AXI-Lite responder with a bank of NUM_REGS 32-bit registers exported flat.
// Optional read-only status slot in the last register: define AXIL_SLV_RO_STATUS_EN.
module axi_lite_slave_regs #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 32
) (
   input  logic                     aclk,
   input  logic                     areset_n,
`ifdef AXIL_SLV_RO_STATUS_EN
   input  logic [31:0]              status_in,
`endif
   input  logic [ADDR_W-1:0]        AWADDR,
   input  logic                     AWVALID,
   output logic                     AWREADY,
   input  logic [31:0]              WDATA,
   input  logic [3:0]               WSTRB,
   input  logic                     WVALID,
   output logic                     WREADY,
   output logic [1:0]               BRESP,
   output logic                     BVALID,
   input  logic                     BREADY,
   input  logic [ADDR_W-1:0]        ARADDR,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   output logic [31:0]              RDATA,
   output logic [1:0]               RRESP,
   output logic                     RVALID,
   input  logic                     RREADY,
   output logic [NUM_REGS*32-1:0]   regs_q,
   output logic [NUM_REGS-1:0]      wr_pulse
);

   localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(NUM_REGS - 1);

   typedef enum logic [1:0] {WS_IDLE = 2'd0, WS_COMMIT = 2'd1, WS_RESP = 2'd2} ws_t;
   typedef enum logic       {RS_IDLE = 1'b0, RS_DATA = 1'b1} rs_t;

   ws_t               ws_state_r, ws_next_s;
   rs_t               rs_state_r, rs_next_s;
   logic              awready_r, wready_r, arready_r;
   logic              aw_held_r, w_held_r;
   logic [ADDR_W-1:0] awaddr_r;
   logic [31:0]       wdata_r;
   logic [3:0]        wstrb_r;
   logic              bvalid_r, rvalid_r;
   logic [1:0]        bresp_r, rresp_r;
   logic [31:0]       rdata_r;
   logic [31:0]       regs_r [NUM_REGS];
   logic [NUM_REGS-1:0] wr_pulse_r;

   logic              aw_hs_s, w_hs_s, ar_hs_s;
   logic [ADDR_W-1:0] w_idx_s, r_idx_s;
   logic              w_ok_s, r_ok_s;
   logic [31:0]       rd_sel_s;

   assign aw_hs_s = AWVALID && awready_r;
   assign w_hs_s  = WVALID && wready_r;
   assign ar_hs_s = ARVALID && arready_r;
   // Shifting the whole address keeps the ignored byte-offset bits out of the index.
   assign w_idx_s = awaddr_r >> 2'd2;
   assign r_idx_s = ARADDR >> 2'd2;
   assign r_ok_s  = (r_idx_s < NUM_REGS_A);
`ifdef AXIL_SLV_RO_STATUS_EN
   assign w_ok_s  = (w_idx_s < NUM_REGS_A) && (w_idx_s != LAST_A);
`else
   assign w_ok_s  = (w_idx_s < NUM_REGS_A);
`endif

   // Read-data mux for the register selected by ARADDR
   always_comb begin
      rd_sel_s = 32'h0000_0000;
      if (!r_ok_s) begin
         rd_sel_s = 32'h0000_0000;
`ifdef AXIL_SLV_RO_STATUS_EN
      end else if (r_idx_s == LAST_A) begin
         rd_sel_s = status_in;
`endif
      end else begin
         rd_sel_s = regs_r[r_idx_s[IDX_W-1:0]];
      end
   end

   // Write FSM next-state logic
   always_comb begin
      ws_next_s = ws_state_r;
      case (ws_state_r)
         WS_IDLE:   if (aw_held_r && w_held_r) ws_next_s = WS_COMMIT; else ws_next_s = WS_IDLE;
         WS_COMMIT: ws_next_s = WS_RESP;
         WS_RESP:   if (BREADY) ws_next_s = WS_IDLE; else ws_next_s = WS_RESP;
         default:   ws_next_s = WS_IDLE;
      endcase
   end

   // Read FSM next-state logic
   always_comb begin
      rs_next_s = rs_state_r;
      case (rs_state_r)
         RS_IDLE: if (ar_hs_s) rs_next_s = RS_DATA; else rs_next_s = RS_IDLE;
         RS_DATA: if (RREADY) rs_next_s = RS_IDLE; else rs_next_s = RS_DATA;
         default: rs_next_s = RS_IDLE;
      endcase
   end

   // FSM state registers
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         ws_state_r <= WS_IDLE;
         rs_state_r <= RS_IDLE;
      end else begin
         ws_state_r <= ws_next_s;
         rs_state_r <= rs_next_s;
      end
   end

   // Write channel capture, register commit, response and write pulses
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         aw_held_r  <= 1'b0;
         w_held_r   <= 1'b0;
         awaddr_r   <= '0;
         wdata_r    <= 32'h0000_0000;
         wstrb_r    <= 4'h0;
         bvalid_r   <= 1'b0;
         bresp_r    <= 2'b00;
         wr_pulse_r <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0000_0000;
      end else begin
         wr_pulse_r <= '0;
         case (ws_state_r)
            WS_IDLE: begin
               if (aw_hs_s) begin
                  awaddr_r  <= AWADDR;
                  aw_held_r <= 1'b1;
               end
               if (w_hs_s) begin
                  wdata_r  <= WDATA;
                  wstrb_r  <= WSTRB;
                  w_held_r <= 1'b1;
               end
            end
            WS_COMMIT: begin
               aw_held_r <= 1'b0;
               w_held_r  <= 1'b0;
               bvalid_r  <= 1'b1;
               bresp_r   <= w_ok_s ? 2'b00 : 2'b10;
               if (w_ok_s) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wstrb_r[b]) regs_r[w_idx_s[IDX_W-1:0]][8*b +: 8] <= wdata_r[8*b +: 8];
                  end
                  wr_pulse_r[w_idx_s[IDX_W-1:0]] <= 1'b1;
               end
            end
            WS_RESP: begin
               if (BREADY) begin
                  bvalid_r <= 1'b0;
                  bresp_r  <= 2'b00;
               end
            end
            default: begin
               aw_held_r <= 1'b0;
               w_held_r  <= 1'b0;
            end
         endcase
         awready_r <= (ws_next_s == WS_IDLE) && !(aw_held_r || aw_hs_s);
         wready_r  <= (ws_next_s == WS_IDLE) && !(w_held_r || w_hs_s);
      end
   end

   // Read channel: sample selected register on AR handshake, hold until R handshake
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'h0000_0000;
         rresp_r   <= 2'b00;
      end else begin
         case (rs_state_r)
            RS_IDLE: begin
               if (ar_hs_s) begin
                  rvalid_r <= 1'b1;
                  rdata_r  <= rd_sel_s;
                  rresp_r  <= r_ok_s ? 2'b00 : 2'b10;
               end
            end
            RS_DATA: begin
               if (RREADY) rvalid_r <= 1'b0;
            end
            default: rvalid_r <= 1'b0;
         endcase
         arready_r <= (rs_next_s == RS_IDLE);
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_q
`ifdef AXIL_SLV_RO_STATUS_EN
      if (g == NUM_REGS - 1) begin : g_status
         assign regs_q[32*g +: 32] = status_in;
      end else begin : g_rw
         assign regs_q[32*g +: 32] = regs_r[g];
      end
`else
      assign regs_q[32*g +: 32] = regs_r[g];
`endif
   end

   assign AWREADY  = awready_r;
   assign WREADY   = wready_r;
   assign BVALID   = bvalid_r;
   assign BRESP    = bresp_r;
   assign ARREADY  = arready_r;
   assign RVALID   = rvalid_r;
   assign RDATA    = rdata_r;
   assign RRESP    = rresp_r;
   assign wr_pulse = wr_pulse_r;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed self-checking bench for axi_lite_slave_regs (default build, NUM_REGS=8).
module tb_axi_lite_slave_regs;

   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 32;

   logic                   aclk;
   logic                   areset_n;
   logic [31:0]            status_in;
   logic [ADDR_W-1:0]      AWADDR;
   logic                   AWVALID;
   logic                   AWREADY;
   logic [31:0]            WDATA;
   logic [3:0]             WSTRB;
   logic                   WVALID;
   logic                   WREADY;
   logic [1:0]             BRESP;
   logic                   BVALID;
   logic                   BREADY;
   logic [ADDR_W-1:0]      ARADDR;
   logic                   ARVALID;
   logic                   ARREADY;
   logic [31:0]            RDATA;
   logic [1:0]             RRESP;
   logic                   RVALID;
   logic                   RREADY;
   logic [NUM_REGS*32-1:0] regs_q;
   logic [NUM_REGS-1:0]    wr_pulse;

   int checks = 0;
   int errors = 0;

   axi_lite_slave_regs #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
      .aclk     (aclk),
      .areset_n (areset_n),
`ifdef AXIL_SLV_RO_STATUS_EN
      .status_in(status_in),
`endif
      .AWADDR   (AWADDR),
      .AWVALID  (AWVALID),
      .AWREADY  (AWREADY),
      .WDATA    (WDATA),
      .WSTRB    (WSTRB),
      .WVALID   (WVALID),
      .WREADY   (WREADY),
      .BRESP    (BRESP),
      .BVALID   (BVALID),
      .BREADY   (BREADY),
      .ARADDR   (ARADDR),
      .ARVALID  (ARVALID),
      .ARREADY  (ARREADY),
      .RDATA    (RDATA),
      .RRESP    (RRESP),
      .RVALID   (RVALID),
      .RREADY   (RREADY),
      .regs_q   (regs_q),
      .wr_pulse (wr_pulse)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_b();
      for (int i = 0; i < 20 && BVALID !== 1'b1; i++) step();
      chk("bvalid_wait", BVALID, 1'b1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [NUM_REGS-1:0] pulse);
      AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
      for (int i = 0; i < 20 && !(AWREADY === 1'b1 && WREADY === 1'b1); i++) step();
      step();
      AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      wait_b();
      resp = BRESP; pulse = wr_pulse;
      BREADY = 1'b1;
      step();
      BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
      ARADDR = a; ARVALID = 1'b1;
      for (int i = 0; i < 20 && ARREADY !== 1'b1; i++) step();
      step();
      ARVALID = 1'b0;
      chk("r_latency", RVALID, 1'b1);
      data = RDATA; resp = RRESP;
      RREADY = 1'b1;
      step();
      RREADY = 1'b0;
   endtask

   initial begin
      logic [1:0]             resp;
      logic [NUM_REGS-1:0]    pulse;
      logic [31:0]            data;
      logic [NUM_REGS*32-1:0] snap;

      areset_n = 1'b0; status_in = 32'h0000_0000;
      AWADDR = 32'h0; AWVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0;
      BREADY = 1'b0; ARADDR = 32'h0; ARVALID = 1'b0; RREADY = 1'b0;
      repeat (3) step();

      // reset state
      chk("rst_awready", AWREADY, 1'b0);
      chk("rst_wready", WREADY, 1'b0);
      chk("rst_arready", ARREADY, 1'b0);
      chk("rst_bvalid", BVALID, 1'b0);
      chk("rst_rvalid", RVALID, 1'b0);
      chk("rst_rdata", RDATA, 32'h0);
      chk("rst_resp", {BRESP, RRESP}, 4'h0);
      chk("rst_regs_q", regs_q, 256'h0);
      chk("rst_wr_pulse", wr_pulse, 8'h00);
      areset_n = 1'b1;
      chk("ready_before_edge", AWREADY, 1'b0);
      step();
      chk("ready_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

      // AW one cycle before W, full strobe, latency checks
      BREADY = 1'b1;
      AWADDR = 32'h4; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("t1_awready_drop", AWREADY, 1'b0);
      chk("t1_wready_up", WREADY, 1'b1);
      WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      chk("t1_bvalid_c0", BVALID, 1'b0);
      step();
      chk("t1_bvalid_c1", BVALID, 1'b0);
      chk("t1_pulse_early", wr_pulse, 8'h00);
      step();
      chk("t1_bvalid_c2", BVALID, 1'b1);
      chk("t1_bresp", BRESP, 2'b00);
      chk("t1_reg1", regs_q[63:32], 32'hDEAD_BEEF);
      chk("t1_pulse", wr_pulse, 8'h02);
      step();
      chk("t1_bvalid_clr", BVALID, 1'b0);
      chk("t1_pulse_1cyc", wr_pulse, 8'h00);
      chk("t1_readies_back", {AWREADY, WREADY}, 2'b11);
      BREADY = 1'b0;

      // W three cycles before AW, partial strobe
      WDATA = 32'h1234_5678; WSTRB = 4'h3; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      chk("t2_wready_drop", WREADY, 1'b0);
      chk("t2_bvalid_wait", BVALID, 1'b0);
      step();
      step();
      AWADDR = 32'h4; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      wait_b();
      chk("t2_bresp", BRESP, 2'b00);
      chk("t2_reg1", regs_q[63:32], 32'hDEAD_5678);
      chk("t2_pulse", wr_pulse, 8'h02);
      BREADY = 1'b1;
      step();
      BREADY = 1'b0;

      // zero strobe: OKAY, no data change, pulse still fires
      do_write(32'h4, 32'hFFFF_FFFF, 4'h0, resp, pulse);
      chk("t3_bresp", resp, 2'b00);
      chk("t3_pulse", pulse, 8'h02);
      chk("t3_reg1", regs_q[63:32], 32'hDEAD_5678);

      // out-of-range write with BREADY stalled
      snap = regs_q;
      AWADDR = 32'h40; WDATA = 32'hCAFE_F00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      wait_b();
      chk("t4_bresp", BRESP, 2'b10);
      chk("t4_pulse", wr_pulse, 8'h00);
      chk("t4_regs", regs_q, snap);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_stall_bvalid", BVALID, 1'b1);
         chk("t4_stall_bresp", BRESP, 2'b10);
         chk("t4_stall_readies", {AWREADY, WREADY}, 2'b00);
      end
      BREADY = 1'b1;
      step();
      BREADY = 1'b0;
      chk("t4_bvalid_clr", BVALID, 1'b0);
      do_read(32'h40, data, resp);
      chk("t4_rdata", data, 32'h0);
      chk("t4_rresp", resp, 2'b10);

      // read with RREADY held low five cycles
      chk("t5_arready", ARREADY, 1'b1);
      ARADDR = 32'h4; ARVALID = 1'b1;
      step();
      ARVALID = 1'b0;
      chk("t5_rvalid", RVALID, 1'b1);
      chk("t5_rdata", RDATA, 32'hDEAD_5678);
      chk("t5_rresp", RRESP, 2'b00);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_hold_rvalid", RVALID, 1'b1);
         chk("t5_hold_rdata", RDATA, 32'hDEAD_5678);
         chk("t5_hold_arready", ARREADY, 1'b0);
      end
      RREADY = 1'b1;
      step();
      RREADY = 1'b0;
      chk("t5_rvalid_clr", RVALID, 1'b0);
      chk("t5_arready_back", ARREADY, 1'b1);

      // AR handshake in the commit cycle of a write to the same register
      BREADY = 1'b1;
      AWADDR = 32'h8; WDATA = 32'hA5A5_A5A5; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      step();
      AWVALID = 1'b0; WVALID = 1'b0;
      step();
      chk("t6_arready", ARREADY, 1'b1);
      ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b1;
      step();
      ARVALID = 1'b0;
      chk("t6_rvalid", RVALID, 1'b1);
      chk("t6_rdata_old", RDATA, 32'h0);
      chk("t6_bvalid", BVALID, 1'b1);
      chk("t6_reg2", regs_q[95:64], 32'hA5A5_A5A5);
      step();
      RREADY = 1'b0; BREADY = 1'b0;
      do_read(32'h8, data, resp);
      chk("t6_rdata_new", data, 32'hA5A5_A5A5);
      chk("t6_rresp", resp, 2'b00);

      // reset between AW and W
      AWADDR = 32'hC; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      chk("t7_aw_captured", AWREADY, 1'b0);
      areset_n = 1'b0;
      #1;
      chk("t7_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
      chk("t7_rst_valid", {BVALID, RVALID}, 2'b00);
      chk("t7_rst_regs", regs_q, 256'h0);
      chk("t7_rst_misc", {RDATA, BRESP, RRESP, wr_pulse}, 44'h0);
      step();
      areset_n = 1'b1;
      step();
      WDATA = 32'h1111_2222; WSTRB = 4'hF; WVALID = 1'b1;
      step();
      WVALID = 1'b0;
      step();
      step();
      chk("t7_no_stale_b", BVALID, 1'b0);
      chk("t7_no_stale_reg", regs_q, 256'h0);
      AWADDR = 32'h10; AWVALID = 1'b1;
      step();
      AWVALID = 1'b0;
      wait_b();
      BREADY = 1'b1;
      step();
      BREADY = 1'b0;
      chk("t7_w_only_reg4", regs_q[159:128], 32'h1111_2222);
      do_write(32'hC, 32'h0BAD_F00D, 4'hF, resp, pulse);
      chk("t7_bresp", resp, 2'b00);
      chk("t7_pulse", pulse, 8'h08);
      chk("t7_reg3", regs_q[127:96], 32'h0BAD_F00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
